// File: rtl/rgen_register_access_pkg.sv
// Shared types for the register-block access controller: response codes and sequencer states.
package rgen_register_access_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } rgen_response_status_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } rgen_access_state_e;

endpackage

// File: rtl/rgen_read_data_selector.sv
// Combines per-register decoder lanes: AND-OR read-data mux, hit/multi-hit flags and the selected lane's wait.
module rgen_read_data_selector #(
  parameter int DATA_WIDTH = 32,
  parameter int REGISTERS  = 1
) (
  input  logic [REGISTERS-1:0]            select,
  input  logic [REGISTERS-1:0]            busy,
  input  logic [REGISTERS*DATA_WIDTH-1:0] read_data,
  output logic                            hit,
  output logic                            multi_hit,
  output logic                            selected_busy,
  output logic [DATA_WIDTH-1:0]           selected_data
);

  // With more than one lane selected the merged busy/data are meaningless; the caller checks multi_hit first.
  always_comb begin
    hit           = 1'b0;
    multi_hit     = 1'b0;
    selected_busy = 1'b0;
    selected_data = '0;
    for (int r = 0; r < REGISTERS; r++) begin
      if (select[r]) begin
        multi_hit     = multi_hit | hit;
        hit           = 1'b1;
        selected_busy = selected_busy | busy[r];
        selected_data = selected_data | read_data[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/rgen_register_access_controller.sv
// Runs one host access at a time into the register array and returns a single buffered response.
// state    | meaning
// IDLE     | ready for a host command
// ACCESS   | strobing decoders, waiting for a single non-waiting hit or timeout
// RESPONSE | holding status/data until the host takes it
module rgen_register_access_controller
  import rgen_register_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int REGISTERS       = 1,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter bit ERROR_ON_NO_HIT = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_command_valid,
  output logic                            o_command_ready,
  input  logic                            i_command_write,
  input  logic [ADDRESS_WIDTH-1:0]        i_command_address,
  input  logic [DATA_WIDTH-1:0]           i_command_write_data,
  input  logic [DATA_WIDTH/8-1:0]         i_command_strobe,
  output logic                            o_response_valid,
  input  logic                            i_response_ready,
  output logic [1:0]                      o_response_status,
  output logic [DATA_WIDTH-1:0]           o_response_read_data,
  output logic                            o_read,
  output logic                            o_write,
  output logic [ADDRESS_WIDTH-1:0]        o_address,
  output logic [DATA_WIDTH-1:0]           o_write_data,
  output logic [DATA_WIDTH/8-1:0]         o_strobe,
  input  logic [REGISTERS-1:0]            i_select,
  input  logic [REGISTERS-1:0]            i_wait,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

  localparam int COUNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  rgen_access_state_e    state, state_next;
  rgen_response_status_e status_q, status_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [COUNT_W-1:0]    count;
  logic                  count_inc;
  logic                  write_q;
  logic                  timeout_hit;
  logic                  hit, multi_hit, selected_busy;
  logic [DATA_WIDTH-1:0] selected_data;

  rgen_read_data_selector #(
    .DATA_WIDTH (DATA_WIDTH),
    .REGISTERS  (REGISTERS)
  ) u_selector (
    .select        (i_select),
    .busy          (i_wait),
    .read_data     (i_read_data),
    .hit           (hit),
    .multi_hit     (multi_hit),
    .selected_busy (selected_busy),
    .selected_data (selected_data)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == COUNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next  = state;
    status_next = OKAY;
    data_next   = '0;
    count_inc   = 1'b0;
    case (state)
      IDLE: if (i_command_valid) state_next = ACCESS;
      ACCESS: begin
        if (!hit) begin
          status_next = ERROR_ON_NO_HIT ? DECERR : OKAY;
          state_next  = RESPONSE;
        end else if (multi_hit) begin
          status_next = SLVERR;
          state_next  = RESPONSE;
        end else if (selected_busy) begin
          if (timeout_hit) begin
            status_next = SLVERR;
            state_next  = RESPONSE;
          end else begin
            count_inc = 1'b1;
          end
        end else begin
          data_next  = write_q ? '0 : selected_data;
          state_next = RESPONSE;
        end
      end
      RESPONSE: if (i_response_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      write_q              <= 1'b0;
      o_address            <= '0;
      o_write_data         <= '0;
      o_strobe             <= '0;
      status_q             <= OKAY;
      o_response_read_data <= '0;
      count                <= '0;
    end else begin
      if (state == IDLE && i_command_valid) begin
        write_q      <= i_command_write;
        o_address    <= i_command_address;
        o_write_data <= i_command_write_data;
        o_strobe     <= i_command_strobe;
      end
      if (state == ACCESS && state_next == RESPONSE) begin
        status_q             <= status_next;
        o_response_read_data <= data_next;
      end
      if (count_inc)                                count <= count + 1'b1;
      else if (state == RESPONSE && i_response_ready) count <= '0;
    end
  end

  // Strobes decode straight from the state register so a reset drops them without waiting for a clock.
  assign o_command_ready   = (state == IDLE);
  assign o_response_valid  = (state == RESPONSE);
  assign o_read            = (state == ACCESS) && !write_q;
  assign o_write           = (state == ACCESS) && write_q;
  assign o_response_status = status_q;

endmodule
